// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester round-robin mux arbiter.
// Optional burst limiting is enabled by defining MUX_ARB_BURST_LIMIT_EN.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_e;

    localparam int unsigned DATA_W_DEFAULT    = 8;
    localparam int unsigned MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mux_arb_fsm.sv
// Grant sequencer: state register, round-robin pointer, select and (when
// MUX_ARB_BURST_LIMIT_EN is defined) the consecutive-transfer burst counter.
module mux_arb_fsm
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel
);

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   sel_q, sel_d;
    logic   limit_hit;

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("mux_arb_fsm: MAX_BURST must be at least 1");
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int unsigned      CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign limit_hit = (cnt_q == CNT_LAST);

    // Staying in G0/G1 implies the grantee's req is high, so every held
    // grant cycle is a transfer and the count needs no extra qualification.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else if (!limit_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? ST_G0 : ST_G1;
                end else if (req0) begin
                    state_d = ST_G0;
                end else if (req1) begin
                    state_d = ST_G1;
                end
            end
            ST_G0: begin
                if (!req0) begin
                    state_d = req1 ? ST_G1 : ST_IDLE;
                end else if (req1 && limit_hit) begin
                    state_d = ST_G1;
                end
            end
            ST_G1: begin
                if (!req1) begin
                    state_d = req0 ? ST_G0 : ST_IDLE;
                end else if (req0 && limit_hit) begin
                    state_d = ST_G0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer and select track the grantee; both hold while idle.
    always_comb begin
        last_d = last_q;
        sel_d  = sel_q;
        if (state_d == ST_G0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (state_d == ST_G1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign gnt0 = (state_q == ST_G0);
    assign gnt1 = (state_q == ST_G1);
    assign sel  = sel_q;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter owning a 2:1 data select and output register.
// Define MUX_ARB_BURST_LIMIT_EN to bound a grant to MAX_BURST cycles under contention.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] y,
    output logic              y_valid
);

    logic              xfer;
    logic [DATA_W-1:0] y_q, y_d;
    logic              y_valid_q, y_valid_d;

    mux_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk (clk),
        .rst (rst),
        .req0(req0),
        .req1(req1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .sel (sel)
    );

    // A granted requester with req low contributes no word that cycle.
    assign xfer = (gnt0 && req0) || (gnt1 && req1);

    always_comb begin
        y_d       = y_q;
        y_valid_d = 1'b0;
        if (xfer) begin
            y_d       = sel ? d1 : d0;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized traffic
// against a grant-ownership reference model (honours MUX_ARB_BURST_LIMIT_EN).
module tb_mux_arbiter;

    localparam int unsigned DW   = 8;
    localparam int          MAXB = 4;
`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [DW-1:0] d0   = '0;
    logic [DW-1:0] d1   = '0;
    logic          gnt0, gnt1, sel, y_valid;
    logic [DW-1:0] y;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who owns the path (-1 none), who owned it last,
    // how many cycles the current owner has held it, and the output word.
    int            m_owner;
    int            m_last;
    int            m_run;
    bit            m_sel;
    logic [DW-1:0] m_y;
    bit            m_yv;

    mux_arbiter #(
        .DATA_W   (DW),
        .MAX_BURST(MAXB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .d0     (d0),
        .d1     (d1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .sel    (sel),
        .y      (y),
        .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_run   = 0;
        m_sel   = 1'b0;
        m_y     = '0;
        m_yv    = 1'b0;
    endtask

    task automatic model_step(input bit r0, input bit r1, input logic [DW-1:0] a,
                              input logic [DW-1:0] b);
        int nxt;
        bit mine, other;
        mine  = (m_owner == 0) ? r0 : r1;
        other = (m_owner == 0) ? r1 : r0;
        if (m_owner >= 0 && mine) begin
            m_y  = (m_owner == 0) ? a : b;
            m_yv = 1'b1;
        end else begin
            m_yv = 1'b0;
        end
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = 1 - m_last;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else if (!mine) begin
            nxt = other ? 1 - m_owner : -1;
        end else if (other && BURST_EN && m_run >= MAXB) begin
            nxt = 1 - m_owner;
        end else begin
            nxt = m_owner;
        end
        if (nxt < 0)             m_run = 0;
        else if (nxt == m_owner) m_run++;
        else                     m_run = 1;
        if (nxt >= 0) begin
            m_last = nxt;
            m_sel  = (nxt == 1);
        end
        m_owner = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(req0, req1, d0, d1);
        #1;
        check("gnt0", gnt0, (m_owner == 0));
        check("gnt1", gnt1, (m_owner == 1));
        check("sel", sel, m_sel);
        check("y_valid", y_valid, m_yv);
        check("y", y, m_y);
    endtask

    initial begin
        model_reset();

        // Reset held while both request
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        tick();
        tick();
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_sel", sel, 0);
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        rst = 1'b0;
        tick();
        check("first_tie_gnt0", gnt0, 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Single requester stream
        req0 = 1'b1; d0 = 8'hA1;
        tick();
        check("single_gnt0", gnt0, 1);
        tick();
        check("single_y_a1", y, 8'hA1);
        check("single_v_a1", y_valid, 1);
        d0 = 8'hA2;
        tick();
        check("single_y_a2", y, 8'hA2);
        d0 = 8'hA3;
        tick();
        check("single_y_a3", y, 8'hA3);
        check("single_v_a3", y_valid, 1);
        req0 = 1'b0;
        tick();
        check("single_drop_gnt0", gnt0, 0);
        check("single_drop_v", y_valid, 0);
        check("single_hold_y", y, 8'hA3);

        // Handover G0 -> G1
        req0 = 1'b1; d0 = 8'h11;
        tick();
        tick();
        req0 = 1'b0; req1 = 1'b1; d1 = 8'h5C;
        tick();
        check("hand_gnt1", gnt1, 1);
        check("hand_sel", sel, 1);
        tick();
        check("hand_y", y, 8'h5C);
        check("hand_v", y_valid, 1);
        req1 = 1'b0;
        tick();

        // Ties from IDLE alternate
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie1_gnt0", gnt0, 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie2_gnt1", gnt1, 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Sustained contention
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            tick();
            check("burst_gnt0", gnt0, BURST_EN ? (((k - 1) / MAXB) % 2 == 0) : 1);
            if (k >= 2) check("burst_v", y_valid, 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-grant
        req1 = 1'b1; d1 = 8'h77;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt1", gnt1, 0);
        check("async_v", y_valid, 0);
        check("async_sel", sel, 0);
        check("async_y", y, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_gnt1", gnt1, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns a shared 2:1 data-select path and its output register. Each requester raises a request with its data word; the arbiter grants one at a time, drives the select, and registers the chosen word onto a single output with a valid flag. It sits between two producers and one shared downstream consumer, and is the sequencing block for the 2:1 select datapath.

## Interface
- DATA_W, 8, width of each data input and of the output word
- MAX_BURST, 4, max consecutive grant cycles while the other requester waits (≥1; used only with the burst-limit feature)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 wants the path; held high while it has data
- req1  input  1  requester 1 wants the path
- d0  input  DATA_W  requester 0 data
- d1  input  DATA_W  requester 1 data
- gnt0  output  1  requester 0 owns the path this cycle
- gnt1  output  1  requester 1 owns the path this cycle
- sel  output  1  current select (0 = d0, 1 = d1)
- y  output  DATA_W  registered selected data
- y_valid  output  1  y holds a word transferred in the previous cycle

## Operation
- FSM states: IDLE=2'b00, G0=2'b01, G1=2'b10. Moore outputs: gnt0=(state==G0), gnt1=(state==G1). Never both high.
- Pointer `last` records the most recent grantee; it updates on every entry to G0/G1.
- IDLE: req0&req1 → grant the requester not equal to `last`; req0 only → G0; req1 only → G1; none → IDLE.
- G0: !req0&req1 → G1; !req0&!req1 → IDLE; req0 → stay (subject to the burst limit). G1 is symmetric.
- Direct G0↔G1 handover, no IDLE bubble.
- sel = 1 in G1, 0 in G0, holds its last value in IDLE.
- Transfer: a cycle with (gnt0&req0) or (gnt1&req1). On a transfer, y <= selected d and y_valid <= 1. Otherwise y_valid <= 0 and y holds.
- A requester that drops req while granted loses the grant at the next edge; data is not sampled in the cycle req is low.
- Reset values: state=IDLE, gnt0=gnt1=0, sel=0, y=0, y_valid=0, last=1 (requester 0 wins the first tie), burst counter=0.
- Reset asserted mid-burst clears everything immediately. No transfer is in flight after release.

## Timing
- req rises in cycle n (from IDLE) → gnt high in cycle n+1 → y/y_valid valid in cycle n+2. Request-to-output latency is 2 cycles.
- With a continuous grant and req held, throughput is 1 word/cycle. y_valid stays high continuously, including across a G0→G1 handover.
- After a handover edge, the grant changes in the same cycle sel changes. The first word from the new grantee appears one cycle later.

## Configuration
- MUX_ARB_BURST_LIMIT_EN defined:
  - A counter (width clog2(MAX_BURST)+1) counts consecutive transfer cycles in the current grant. It resets to 0 on any state change.
  - In G0, if req0, req1 and count==MAX_BURST-1, the next state is G1. G1 is symmetric.
  - If the other side is not requesting, the grant continues and the counter saturates at MAX_BURST-1.
- Not defined: no counter. A granted requester keeps the path as long as its req stays high. Round-robin applies only at IDLE ties and handovers.

## Structure
- Shared package mux_arb_pkg: state encodings (ST_IDLE, ST_G0, ST_G1) and the DATA_W default.
- One sub-module, mux_arb_fsm: state register, `last` pointer and burst counter; outputs gnt0/gnt1/sel. Top level mux_arbiter holds the data select and the y/y_valid register.

## Test plan
- Reset: drive rst=1 with req0=req1=1 → gnt0=gnt1=0, sel=0, y=0, y_valid=0. After release, the first grant is gnt0.
- Single requester: req0=1 for 3 cycles with d0=8'hA1,A2,A3 → gnt0 high from cycle 1; y=A1,A2,A3 with y_valid high in cycles 2–4; gnt0 low the edge after req0 drops.
- Tie from IDLE twice: req0=req1=1 one cycle then drop, repeat → first grant G0, second grant G1 (alternates).
- Burst limit (macro on, MAX_BURST=4): req0 and req1 held high → gnt0 for 4 cycles, gnt1 for 4, alternating, with y_valid continuously 1. With the macro off → gnt0 held indefinitely.
- Handover: in G0, req0 drops while req1=1, d1=8'h5C → next cycle gnt1=1, sel=1; the following cycle y=8'h5C with no y_valid gap beyond the dropped cycle.
- Mid-burst reset: assert rst during G1 → gnt1, y_valid, sel cleared asynchronously. After release with req1 only, gnt1 returns after 1 cycle.
